// File: rtl/clock_pkg.sv
// Shared types and limits for the time-of-day set logic.
package clock_pkg;

   // Field selector as seen on field_sel.
   typedef enum logic [1:0] {
      NONE = 2'b00,
      HOUR = 2'b01,
      MIN  = 2'b10,
      SEC  = 2'b11
   } field_e;

   // Editor FSM states; encoding matches the field each state edits.
   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      EDIT_HOUR = 2'b01,
      EDIT_MIN  = 2'b10,
      EDIT_SEC  = 2'b11
   } state_e;

   localparam int HOUR_MAX = 23;
   localparam int MIN_MAX  = 59;
   localparam int SEC_MAX  = 59;

   // Next field in the HOUR -> MIN -> SEC -> HOUR rotation.
   function automatic state_e next_edit(input state_e s);
      case (s)
         EDIT_HOUR: return EDIT_MIN;
         EDIT_MIN:  return EDIT_SEC;
         default:   return EDIT_HOUR;
      endcase
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// Up/down modulo counter (0..MAX) with synchronous load.
// Load has priority over inc, inc over dec; the caller never asserts both.
module wrap_counter #(
   parameter int WIDTH = 6,
   parameter int MAX   = 59
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [WIDTH-1:0] o_count
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   logic [WIDTH-1:0] r_count;

   // Count register: load, or step one with wrap at 0 and MAX.
   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_inc) begin
         r_count <= (r_count == MAX_V) ? '0 : r_count + 1'b1;
      end else if (i_dec) begin
         r_count <= (r_count == '0) ? MAX_V : r_count - 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/time_set_unit.sv
// Time-setting editor: captures the running time on entry, lets the user
// step through hour/minute/second with inc/dec keys, and pulses time_load
// on exit when anything was changed.
module time_set_unit
   import clock_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       set_time_en,
   input  logic       shift_key,
   input  logic       inc_key,
   input  logic       dec_key,
   input  logic       tick_2hz,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_sec,
   output logic [4:0] set_hour,
   output logic [5:0] set_min,
   output logic [5:0] set_sec,
   output logic       time_load,
   output logic [1:0] field_sel,
   output logic       blink
);

   state_e r_state;
   field_e r_field;
   logic   r_blink;
   logic   r_time_load;
   logic   r_dirty;
   logic   r_en_d;
   // Low for the first clock after reset so an enable already high at
   // release is absorbed into r_en_d instead of reading as a rising edge.
   logic   r_arm;

   logic   w_edge;
   logic   w_entry;
   logic   w_active;
   logic   w_step;
   logic   w_inc;
   logic   w_dec;

   assign w_edge   = r_arm & set_time_en & ~r_en_d;
   assign w_entry  = (r_state == IDLE) & w_edge;
   assign w_active = (r_state != IDLE) & set_time_en;
   // inc and dec together cancel out.
   assign w_step   = w_active & (inc_key ^ dec_key);
   assign w_inc    = w_step & inc_key;
   assign w_dec    = w_step & dec_key;

   wrap_counter #(.WIDTH(5), .MAX(HOUR_MAX)) u_hour (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_entry),
      .i_load_val (cur_hour),
      .i_inc      (w_inc & (r_state == EDIT_HOUR)),
      .i_dec      (w_dec & (r_state == EDIT_HOUR)),
      .o_count    (set_hour)
   );

   wrap_counter #(.WIDTH(6), .MAX(MIN_MAX)) u_min (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_entry),
      .i_load_val (cur_min),
      .i_inc      (w_inc & (r_state == EDIT_MIN)),
      .i_dec      (w_dec & (r_state == EDIT_MIN)),
      .o_count    (set_min)
   );

   wrap_counter #(.WIDTH(6), .MAX(SEC_MAX)) u_sec (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_entry),
      .i_load_val (cur_sec),
      .i_inc      (w_inc & (r_state == EDIT_SEC)),
      .i_dec      (w_dec & (r_state == EDIT_SEC)),
      .o_count    (set_sec)
   );

   // Editor FSM with registered field, blink, dirty and load-pulse outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_field     <= NONE;
         r_blink     <= 1'b0;
         r_time_load <= 1'b0;
         r_dirty     <= 1'b0;
         r_en_d      <= 1'b0;
         r_arm       <= 1'b0;
      end else begin
         r_en_d      <= set_time_en;
         r_arm       <= 1'b1;
         r_time_load <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_edge) begin
                  r_state <= EDIT_HOUR;
                  r_field <= HOUR;
                  r_dirty <= 1'b0;
                  r_blink <= 1'b0;
               end
            end
            default: begin
               if (!set_time_en) begin
                  // Keys in this cycle are dropped; only the load decision counts.
                  r_state     <= IDLE;
                  r_field     <= NONE;
                  r_time_load <= r_dirty;
                  r_blink     <= 1'b0;
               end else begin
                  if (w_step) begin
                     r_dirty <= 1'b1;
                  end
                  if (shift_key) begin
                     r_state <= next_edit(r_state);
                     r_field <= field_e'(next_edit(r_state));
                  end
                  // Any applied key makes the field visible straight away.
                  if (w_step || shift_key) begin
                     r_blink <= 1'b0;
                  end else if (tick_2hz) begin
                     r_blink <= ~r_blink;
                  end
               end
            end
         endcase
      end
   end

   assign time_load = r_time_load;
   assign field_sel = r_field;
   assign blink     = r_blink;

endmodule

// File: tb/tb_time_set_unit.sv
// Bench for time_set_unit: directed scenarios plus randomized key traffic,
// all compared against a behavioural model of the editor.
module tb_time_set_unit;

   logic       clk;
   logic       rst_n;
   logic       set_time_en;
   logic       shift_key;
   logic       inc_key;
   logic       dec_key;
   logic       tick_2hz;
   logic [4:0] cur_hour;
   logic [5:0] cur_min;
   logic [5:0] cur_sec;
   logic [4:0] set_hour;
   logic [5:0] set_min;
   logic [5:0] set_sec;
   logic       time_load;
   logic [1:0] field_sel;
   logic       blink;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: mode 0 = idle, 1 = hour, 2 = minute, 3 = second.
   int m_mode, m_h, m_m, m_s;
   bit m_dirty, m_blink, m_load, m_prev_en, m_armed;

   time_set_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .set_time_en (set_time_en),
      .shift_key   (shift_key),
      .inc_key     (inc_key),
      .dec_key     (dec_key),
      .tick_2hz    (tick_2hz),
      .cur_hour    (cur_hour),
      .cur_min     (cur_min),
      .cur_sec     (cur_sec),
      .set_hour    (set_hour),
      .set_min     (set_min),
      .set_sec     (set_sec),
      .time_load   (time_load),
      .field_sel   (field_sel),
      .blink       (blink)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_mode = 0; m_h = 0; m_m = 0; m_s = 0;
      m_dirty = 0; m_blink = 0; m_load = 0; m_prev_en = 0; m_armed = 0;
   endfunction

   // One rising edge of behaviour, from the inputs present at that edge.
   function automatic void model_step(input bit en, input bit sh, input bit in,
                                      input bit de, input bit tk);
      bit key;
      m_load = 0;
      if (m_mode == 0) begin
         if (m_armed && en && !m_prev_en) begin
            m_mode = 1; m_h = cur_hour; m_m = cur_min; m_s = cur_sec;
            m_dirty = 0; m_blink = 0;
         end
      end else if (!en) begin
         m_load = m_dirty; m_mode = 0; m_blink = 0;
      end else begin
         key = 0;
         if (in != de) begin
            case (m_mode)
               1: m_h = in ? (m_h + 1) % 24 : (m_h + 23) % 24;
               2: m_m = in ? (m_m + 1) % 60 : (m_m + 59) % 60;
               default: m_s = in ? (m_s + 1) % 60 : (m_s + 59) % 60;
            endcase
            m_dirty = 1; key = 1;
         end
         if (sh) begin
            m_mode = (m_mode % 3) + 1; key = 1;
         end
         if (key) m_blink = 0;
         else if (tk) m_blink = !m_blink;
      end
      m_prev_en = en;
      m_armed = 1;
   endfunction

   task automatic compare_all(input string tag);
      check({tag, ".hour"},  32'(set_hour),  32'(m_h));
      check({tag, ".min"},   32'(set_min),   32'(m_m));
      check({tag, ".sec"},   32'(set_sec),   32'(m_s));
      check({tag, ".load"},  32'(time_load), 32'(m_load));
      check({tag, ".field"}, 32'(field_sel), 32'(m_mode));
      check({tag, ".blink"}, 32'(blink),     32'(m_blink));
   endtask

   // Drive one cycle of inputs, clock it, advance the model, compare #1 later.
   task automatic step(input bit en, input bit sh, input bit in, input bit de,
                       input bit tk, input string tag);
      set_time_en = en; shift_key = sh; inc_key = in; dec_key = de; tick_2hz = tk;
      @(posedge clk);
      model_step(en, sh, in, de, tk);
      #1;
      compare_all(tag);
      shift_key = 0; inc_key = 0; dec_key = 0; tick_2hz = 0;
   endtask

   task automatic set_cur(input int h, input int m, input int s);
      cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
   endtask

   // Asynchronous reset pulse in the middle of a cycle.
   task automatic do_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check({tag, ".rst_hour"},  32'(set_hour),  0);
      check({tag, ".rst_min"},   32'(set_min),   0);
      check({tag, ".rst_sec"},   32'(set_sec),   0);
      check({tag, ".rst_load"},  32'(time_load), 0);
      check({tag, ".rst_field"}, 32'(field_sel), 0);
      check({tag, ".rst_blink"}, 32'(blink),     0);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      bit en, sh, in, de, tk;
      rst_n = 1'b0;
      set_time_en = 0; shift_key = 0; inc_key = 0; dec_key = 0; tick_2hz = 0;
      set_cur(0, 0, 0);
      model_reset();
      #3;
      compare_all("reset");
      @(negedge clk) rst_n = 1'b1;
      step(0, 0, 0, 0, 0, "post_reset");

      // Capture on entry.
      set_cur(12, 34, 56);
      step(1, 0, 0, 0, 0, "capture");
      check("capture.field_sel", 32'(field_sel), 1);
      check("capture.hms", {set_hour, set_min, set_sec}, {5'd12, 6'd34, 6'd56});
      step(0, 0, 0, 0, 0, "capture_exit");
      check("capture_exit.no_load", 32'(time_load), 0);

      // Edit with wraps, then load on exit.
      set_cur(23, 0, 0);
      step(1, 0, 0, 0, 0, "edit_enter");
      step(1, 0, 1, 0, 0, "edit_inc");
      check("edit_inc.hour_wrap", 32'(set_hour), 0);
      step(1, 1, 0, 0, 0, "edit_shift");
      check("edit_shift.field", 32'(field_sel), 2);
      step(1, 0, 0, 1, 0, "edit_dec");
      check("edit_dec.min_wrap", 32'(set_min), 59);
      step(0, 0, 0, 0, 0, "edit_exit");
      check("edit_exit.load", 32'(time_load), 1);
      check("edit_exit.field", 32'(field_sel), 0);
      check("edit_exit.hold", {set_hour, set_min}, {5'd0, 6'd59});
      step(0, 0, 0, 0, 0, "edit_after");
      check("edit_after.load_one_cycle", 32'(time_load), 0);

      // Clean session: full shift rotation, no load.
      set_cur(5, 6, 7);
      step(1, 0, 0, 0, 0, "clean_enter");
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, "clean_shift");
      check("clean.field_back_hour", 32'(field_sel), 1);
      step(0, 0, 0, 0, 0, "clean_exit");
      check("clean_exit.no_load", 32'(time_load), 0);

      // Key collisions.
      set_cur(1, 59, 0);
      step(1, 0, 0, 0, 0, "coll_enter");
      step(1, 0, 1, 1, 0, "coll_incdec");
      check("coll_incdec.hour", 32'(set_hour), 1);
      step(0, 0, 0, 0, 0, "coll_exit");
      check("coll_exit.clean", 32'(time_load), 0);
      step(1, 0, 0, 0, 0, "coll_reenter");
      step(1, 1, 0, 0, 0, "coll_to_min");
      step(1, 1, 1, 0, 0, "coll_inc_shift");
      check("coll_inc_shift.min", 32'(set_min), 0);
      check("coll_inc_shift.field", 32'(field_sel), 3);

      // Reset mid-edit; enable held high through reset.
      step(1, 0, 1, 0, 0, "rst_inc1");
      step(1, 0, 1, 0, 0, "rst_inc2");
      do_reset("mid_edit");
      step(1, 0, 0, 0, 0, "rst_hold1");
      step(1, 0, 0, 0, 0, "rst_hold2");
      check("rst_hold.no_entry", 32'(field_sel), 0);
      check("rst_hold.no_load", 32'(time_load), 0);
      step(0, 0, 0, 0, 0, "rst_low");
      step(1, 0, 0, 0, 0, "rst_fresh_edge");
      check("rst_fresh_edge.entry", 32'(field_sel), 1);

      // Blink sequence and forced-visible on inc.
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 0, 1, "blink_tick");
         check("blink_seq", 32'(blink), 32'((i % 2) == 0));
         step(1, 0, 0, 0, 0, "blink_gap");
      end
      step(1, 0, 0, 0, 1, "blink_tick5");
      check("blink_on", 32'(blink), 1);
      step(1, 0, 1, 0, 0, "blink_inc");
      check("blink_inc_clear", 32'(blink), 0);
      step(0, 0, 0, 0, 0, "blink_exit");

      // Randomized traffic against the model.
      en = 0;
      for (int i = 0; i < 1500; i++) begin
         set_cur($urandom_range(23, 0), $urandom_range(59, 0), $urandom_range(59, 0));
         if ($urandom_range(9, 0) == 0) en = !en;
         sh = ($urandom_range(4, 0) == 0);
         in = ($urandom_range(2, 0) == 0);
         de = ($urandom_range(3, 0) == 0);
         tk = ($urandom_range(3, 0) == 0);
         step(en, sh, in, de, tk, "rand");
         if ($urandom_range(199, 0) == 0) do_reset("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/time_set_unit.md
TIME_SET_UNIT -- requirements
Module: time_set_unit

Interface
REQ-001 clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 set_time_en  input  1  level enable from the mode controller; high = time-setting mode active.
REQ-004 shift_key  input  1  single-cycle pulse; advance the edited field.
REQ-005 inc_key  input  1  single-cycle pulse; increment the selected field.
REQ-006 dec_key  input  1  single-cycle pulse; decrement the selected field.
REQ-007 tick_2hz  input  1  single-cycle pulse at 2 Hz, used for blink timing.
REQ-008 cur_hour  input  5  running hour, binary 0..23.
REQ-009 cur_min  input  6  running minute, binary 0..59.
REQ-010 cur_sec  input  6  running second, binary 0..59.
REQ-011 set_hour  output  5  edited hour, binary.
REQ-012 set_min  output  6  edited minute, binary.
REQ-013 set_sec  output  6  edited second, binary.
REQ-014 time_load  output  1  single-cycle pulse; the clock core loads set_* on this pulse.
REQ-015 field_sel  output  2  field being edited: 00 none, 01 hour, 10 minute, 11 second.
REQ-016 blink  output  1  display blanking for the selected field; 1 = blank.

Function
REQ-017 The FSM SHALL have four states: IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC.
REQ-018 field_sel SHALL equal 00/01/10/11 in IDLE/EDIT_HOUR/EDIT_MIN/EDIT_SEC respectively.
REQ-019 Entry: in IDLE, a set_time_en rising edge SHALL take the FSM to EDIT_HOUR on the next cycle.
REQ-020 On that entry cycle, cur_hour/cur_min/cur_sec SHALL be captured into set_*.
REQ-021 On entry, a dirty flag SHALL be cleared.
REQ-022 Rising-edge detection SHALL use a registered copy of set_time_en.
REQ-023 If set_time_en is already high when reset releases, that SHALL NOT count as an entry edge.
REQ-024 shift_key in an edit state SHALL cycle the field HOUR->MIN->SEC->HOUR, one step per pulse.
REQ-025 inc_key SHALL add 1 to the selected field, with wrap: hour 23->0, minute/second 59->0.
REQ-026 dec_key SHALL subtract 1 from the selected field, with wrap: hour 0->23, minute/second 0->59.
REQ-027 Each inc/dec SHALL take effect one cycle after the pulse.
REQ-028 Any applied inc/dec SHALL set the dirty flag.
REQ-029 inc_key and dec_key in the same cycle SHALL change nothing and SHALL NOT set dirty.
REQ-030 inc/dec in the same cycle as shift_key SHALL apply to the currently selected field first; the shift then takes effect.
REQ-031 Exit: set_time_en low in any edit state SHALL return the FSM to IDLE on the next cycle.
REQ-032 On exit, time_load SHALL pulse high for exactly that one cycle, only if dirty=1.
REQ-033 set_* SHALL hold the edited values through the time_load cycle and afterwards until the next entry.
REQ-034 Keys arriving in the exit cycle, and all keys while in IDLE, SHALL be ignored.
REQ-035 blink SHALL be 0 in IDLE and SHALL be cleared to 0 on entry.
REQ-036 blink SHALL toggle on each tick_2hz while in an edit state.
REQ-037 blink SHALL be cleared to 0 on any applied shift, inc or dec, so the field is visible immediately.
REQ-038 All outputs SHALL be registered.

Reset
REQ-039 On rst_n low, the FSM SHALL go to IDLE immediately and asynchronously.
REQ-040 On reset, set_hour/set_min/set_sec SHALL be 0, and time_load, field_sel, blink, dirty and the edge register SHALL be 0.
REQ-041 Reset mid-edit SHALL discard the edit, with no time_load pulse.

Structure
REQ-042 A shared package clock_pkg SHALL hold the field_e enum (NONE, HOUR, MIN, SEC) and the constants HOUR_MAX=23, MIN_MAX=59 and SEC_MAX=59.
REQ-043 The sub-module wrap_counter SHALL be a parameterised-width, parameterised-max up/down modulo counter with load, instantiated three times.

Verification
REQ-044 Capture: cur=12:34:56, raise set_time_en -> EDIT_HOUR next cycle, set_*=12:34:56, field_sel=01.
REQ-045 Edit and load: in EDIT_HOUR with hour=23 apply inc, then shift, then dec with min=0, then drop set_time_en -> hour=0, min=59, time_load one 1-cycle pulse, field_sel=00.
REQ-046 No load when clean: enter, shift three times, exit -> time_load stays 0 and field_sel returns to 01 before exit.
REQ-047 Key collisions: inc+dec together -> no change and dirty=0; inc+shift in EDIT_MIN with min=59 -> min=0 and field moves to SEC.
REQ-048 Reset mid-edit: after two increments, pulse rst_n low -> all outputs 0, no time_load, and re-entry requires a fresh set_time_en edge.
REQ-049 Blink: four tick_2hz pulses in an edit state -> blink sequence 1,0,1,0; an inc between ticks forces blink=0.
